instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//   Supplies the controller with instructions. Reads IR words from a synchronous
//   instruction memory and presents each on IR with a valid/ready handshake.
//   Holds each word until the controller finishes its micro-sequence.
//   Advances or reloads the PC; the controller resolves z and issues any jump.
// PARAMETERS
//   IR_WIDTH    16   instruction width; matches controller IR
//   ADDR_WIDTH  8    instruction memory address / PC width
//   RESET_PC    0    PC value after reset
// PORTS
//   clk          in   1           system clock, rising edge
//   rst_n        in   1           asynchronous active-low reset
//   start        in   1           1-cycle pulse; begin/resume fetching (IDLE/HALT only)
//   imem_rd      out  1           memory read strobe, 1 cycle per fetch
//   imem_addr    out  ADDR_WIDTH  fetch address (= pc)
//   imem_rdata   in   IR_WIDTH    read data, valid the cycle after imem_rd
//   IR           out  IR_WIDTH    current instruction to controller
//   ir_valid     out  1           IR holds a valid instruction
//   ir_ready     in   1           controller done with IR; handshake when ir_valid&ir_ready
//   pc_load      in   1           load pc_load_addr as next fetch address
//   pc_load_addr in   ADDR_WIDTH  jump target
//   halt         in   1           stop after the current handshake
//   pc           out  ADDR_WIDTH  address of IR while ir_valid; next fetch address otherwise
//   halted       out  1           unit is in HALT
//   instr_count  out  16          number of completed handshakes
// BEHAVIOUR
//   Reset (async, immediate, aborts any fetch):
//   - state=IDLE, pc=RESET_PC, IR=0, ir_valid=0, halted=0, instr_count=0.
//   - imem_rd and imem_addr are decoded from state and pc: imem_rd=0, imem_addr=pc.
//   States: IDLE, FETCH, WAIT, HOLD, HALT.
//   - IDLE: outputs quiet. start -> FETCH.
//   - FETCH: imem_rd=1, imem_addr=pc. Next state -> WAIT.
//   - WAIT: IR<=imem_rdata and ir_valid<=1 at cycle end. Next state -> HOLD.
//   - HOLD: ir_valid=1; IR and pc stable. Stays in HOLD until ir_ready.
//     On handshake: instr_count+=1 (wraps 0xFFFF->0); ir_valid<=0.
//     Also pc<=pc_load?pc_load_addr:pc+1, where pc+1 wraps modulo 2^ADDR_WIDTH.
//     Next state on handshake: halt -> HALT, else -> FETCH.
//     If halt and pc_load arrive together, the PC loads and the unit halts.
//   - HALT: halted=1, ir_valid=0. start -> FETCH from the current pc; halted<=0.
//   Latency:
//   - start to first imem_rd: 1 cycle.
//   - imem_rd to ir_valid: 2 cycles.
//   - handshake to next imem_rd: 1 cycle. Steady state is 3 cycles per instruction
//     when ir_ready is tied high.
//   pc_load outside a HOLD handshake:
//   - In FETCH or WAIT: pc<=pc_load_addr and next state is FETCH. Any in-flight
//     rdata is discarded; IR is unchanged and ir_valid stays 0.
//   - In IDLE or HALT: pc<=pc_load_addr; state unchanged (PC preload).
//   - In HOLD without ir_ready: ignored.
//   Other inputs:
//   - start outside IDLE/HALT: ignored.
//   - halt outside a HOLD handshake: ignored.
//   - ir_ready while ir_valid=0: ignored.
// TESTING
//   1 Reset: imem holds 0x0047 at address 0; release rst_n, pulse start ->
//     imem_rd at cycle 1, addr 0. Then ir_valid=1, IR=0x0047, pc=0 at cycle 3.
//   2 Stall: hold ir_ready=0 for 5 cycles -> IR, pc and ir_valid stable, no imem_rd.
//     Then ir_ready=1 -> next fetch at addr 1 and instr_count=1.
//   3 Jump: during HOLD at pc=5, pc_load=1 with addr 0x20 and ir_ready=1 ->
//     next imem_addr=0x20, instr_count increments.
//   4 Flush: pc_load=1 with addr 0x10 during WAIT -> old rdata is never presented,
//     next fetch at 0x10, and IR=mem[0x10] with ir_valid=1.
//   5 Wrap/halt: pc=0xFF handshake -> next fetch at 0x00. halt on handshake ->
//     halted=1 with no imem_rd; start -> fetch resumes at the next pc.
//   6 Reset mid-fetch: drop rst_n during WAIT -> all outputs return to reset
//     values immediately. No ir_valid until start.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: reads IR words from a synchronous instruction memory and
// presents them to the controller over a valid/ready handshake, managing the PC.
module instruction_fetch_unit #(
    parameter int unsigned           IR_WIDTH   = 16,
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  imem_rd,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [IR_WIDTH-1:0]   imem_rdata,
    output logic [IR_WIDTH-1:0]   IR,
    output logic                  ir_valid,
    input  logic                  ir_ready,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_addr,
    input  logic                  halt,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  halted,
    output logic [15:0]           instr_count
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StHold,
        StHalt
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [IR_WIDTH-1:0]   ir_q, ir_d;
    logic [15:0]           count_q, count_d;
    logic [ADDR_WIDTH-1:0] pc_inc;

    assign pc_inc = pc_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        count_d = count_q;

        unique case (state_q)
            StIdle, StHalt: begin
                // pc_load here only preloads the PC for the next start
                if (pc_load) begin
                    pc_d = pc_load_addr;
                end
                if (start) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (pc_load) begin
                    pc_d    = pc_load_addr;
                    state_d = StFetch;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                // A jump while the read is in flight drops the returning word
                if (pc_load) begin
                    pc_d    = pc_load_addr;
                    state_d = StFetch;
                end else begin
                    ir_d    = imem_rdata;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (ir_ready) begin
                    count_d = count_q + 16'd1;
                    pc_d    = pc_load ? pc_load_addr : pc_inc;
                    state_d = halt ? StHalt : StFetch;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign imem_rd     = (state_q == StFetch);
    assign imem_addr   = pc_q;
    assign IR          = ir_q;
    assign ir_valid    = (state_q == StHold);
    assign pc          = pc_q;
    assign halted      = (state_q == StHalt);
    assign instr_count = count_q;

endmodule
